// File: rtl/sqrt_result_checker.sv
// Registered checker placed behind a combinational integer square-root unit: verifies
// u*u <= p < (u+1)*(u+1), buffers checked pairs in a show-ahead FIFO and counts pass/fail.
`timescale 1ns/1ps
module sqrt_result_checker #(
  parameter int unsigned SIZE      = 16,
  parameter int unsigned HALF_SIZE = 8,
  parameter int unsigned DEPTH     = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [SIZE-1:0]      p,
  input  logic [HALF_SIZE-1:0] u,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [SIZE-1:0]      out_p,
  output logic [HALF_SIZE-1:0] out_u,
  output logic                 out_pass,
  input  logic                 clear,
  output logic [15:0]          pass_count,
  output logic [15:0]          fail_count
);
  localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CntW = $clog2(DEPTH + 1);
  localparam logic [CntW:0] DepthW = (CntW + 1)'(DEPTH);

  logic accept, push, pop;

  // Stage A
  logic                 a_v_q;
  logic [SIZE-1:0]      a_p_q;
  logic [HALF_SIZE-1:0] a_u_q;
  logic [SIZE-1:0]      a_sq_lo_q;
  logic [SIZE:0]        a_sq_hi_q;
  logic                 a_pass;

  logic [SIZE-1:0] u_ext;
  logic [SIZE:0]   u_inc;
  logic [SIZE-1:0] sq_lo;
  logic [SIZE:0]   sq_hi;

  // FIFO
  logic [SIZE-1:0]      mem_p    [DEPTH];
  logic [HALF_SIZE-1:0] mem_u    [DEPTH];
  logic                 mem_pass [DEPTH];
  logic [PtrW-1:0]      wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0]      count_q, count_d;
  logic [CntW:0]        occupancy;

  // Counters
  logic [15:0] pass_count_q, pass_count_d;
  logic [15:0] fail_count_q, fail_count_d;

  // Credit covers the FIFO plus the stage A slot; pops are credited a cycle late.
  assign occupancy = {1'b0, count_q} + {{CntW{1'b0}}, a_v_q};
  assign in_ready  = rst_n && (occupancy < DepthW);
  assign accept    = in_valid && in_ready;
  assign push      = a_v_q;
  assign out_valid = (count_q != '0);
  assign pop       = out_valid && out_ready;

  // (u+1)^2 reaches 2^SIZE for an all-ones root, hence the extra bit.
  assign u_ext = {{(SIZE - HALF_SIZE){1'b0}}, u};
  assign u_inc = {1'b0, u_ext} + (SIZE + 1)'(1);
  assign sq_lo = u_ext * u_ext;
  assign sq_hi = u_inc * u_inc;

  assign a_pass = (a_sq_lo_q <= a_p_q) && ({1'b0, a_p_q} < a_sq_hi_q);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      a_v_q     <= 1'b0;
      a_p_q     <= '0;
      a_u_q     <= '0;
      a_sq_lo_q <= '0;
      a_sq_hi_q <= '0;
    end else begin
      a_v_q <= accept;
      if (accept) begin
        a_p_q     <= p;
        a_u_q     <= u;
        a_sq_lo_q <= sq_lo;
        a_sq_hi_q <= sq_hi;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem_p[wr_ptr_q]    <= a_p_q;
      mem_u[wr_ptr_q]    <= a_u_q;
      mem_pass[wr_ptr_q] <= a_pass;
    end
  end

  always_comb begin
    count_d = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + CntW'(1);
      2'b01:   count_d = count_q - CntW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PtrW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PtrW'(1);
      count_q <= count_d;
    end
  end

  // Head is forced to zero when empty so stale storage never shows on the port.
  always_comb begin
    out_p    = '0;
    out_u    = '0;
    out_pass = 1'b0;
    if (out_valid) begin
      out_p    = mem_p[rd_ptr_q];
      out_u    = mem_u[rd_ptr_q];
      out_pass = mem_pass[rd_ptr_q];
    end
  end

  always_comb begin
    pass_count_d = pass_count_q;
    fail_count_d = fail_count_q;
    if (clear) begin
      pass_count_d = '0;
      fail_count_d = '0;
    end else if (push) begin
      if (a_pass) begin
        if (pass_count_q != 16'hFFFF) pass_count_d = pass_count_q + 16'd1;
      end else begin
        if (fail_count_q != 16'hFFFF) fail_count_d = fail_count_q + 16'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pass_count_q <= '0;
      fail_count_q <= '0;
    end else begin
      pass_count_q <= pass_count_d;
      fail_count_q <= fail_count_d;
    end
  end

  assign pass_count = pass_count_q;
  assign fail_count = fail_count_q;

endmodule

// File: doc/sqrt_result_checker.md
# sqrt_result_checker

Registered checking stage placed directly downstream of the combinational binary square-root unit. Each accepted operand/result pair (p, u) is checked against the integer square-root definition u² ≤ p < (u+1)². Checked results are buffered in a small show-ahead FIFO behind a valid/ready output, and saturating pass/fail counters are kept. Used in self-checking benches and on-chip BIST in place of file dumps of p/u pairs.

## Interface
- SIZE, 16: width of operand p; must be even.
- HALF_SIZE, 8: width of root u; must equal SIZE/2.
- DEPTH, 4: FIFO entries; power of two, ≥ 2.

- clk  in  1  rising-edge clock.
- rst_n  in  1  reset, synchronous, active-low.
- in_valid  in  1  p/u pair offered.
- in_ready  out  1  stage can accept a pair this cycle.
- p  in  SIZE  radicand fed to the root unit.
- u  in  HALF_SIZE  root produced by the root unit for p.
- out_valid  out  1  FIFO head holds a checked result.
- out_ready  in  1  consumer takes the head this cycle.
- out_p  out  SIZE  radicand of the head entry.
- out_u  out  HALF_SIZE  root of the head entry.
- out_pass  out  1  1 = head entry satisfied the check.
- clear  in  1  synchronous zeroing of both counters.
- pass_count  out  16  saturating count of passing checks.
- fail_count  out  16  saturating count of failing checks.

## Operation
- Transfer in on a clk edge with in_valid && in_ready; transfer out on an edge with out_valid && out_ready.
- Stage A is a one-entry register: it captures p, u, sq_lo = u·u (SIZE bits, unsigned) and sq_hi = (u+1)·(u+1) (SIZE+1 bits; 2^SIZE when u is all-ones). Stage A valid flag is a_v.
- pass = (sq_lo ≤ p) && ({1'b0,p} < sq_hi), unsigned, computed from stage A.
- When a_v = 1, at the next edge {p, u, pass} is pushed into the FIFO and a_v clears, unless a new pair is accepted on that edge, in which case a_v stays 1.
- Flow control is credit-based: in_ready = rst_n && (fifo_count + a_v < DEPTH). Same-cycle pops are not credited, so the FIFO never overflows and stage A never stalls.
- The FIFO is show-ahead: out_p/out_u/out_pass drive the head entry and hold stable while out_valid && !out_ready.
- Simultaneous push and pop leaves fifo_count unchanged. A pop from an empty FIFO and a push to a full FIFO cannot occur.
- Counters increment on each FIFO push: pass_count if pass, else fail_count. Each saturates at 16'hFFFF.
- clear = 1 forces both counters to 0 at the edge. Clear wins over a same-edge push: that push's count is dropped, but its FIFO entry is still written.
- The datapath is unaffected by clear.

## Timing
- Reset (rst_n = 0 at an edge): a_v = 0, FIFO empty, pass_count = fail_count = 0, out_valid = 0, out_p = out_u = 0, out_pass = 0.
- in_ready is 0 while rst_n = 0 and 1 on the first cycle after reset.
- Reset mid-operation discards stage A and all FIFO contents with no output transfer.
- Latency: for a pair accepted at edge N, the push occurs at edge N+1. out_valid is high after edge N+1 when the FIFO was empty. Counters update at edge N+1.
- Throughput: one pair per cycle while out_ready is held high.
- in_ready falls the cycle after the (DEPTH)th outstanding entry (FIFO plus stage A) is accepted. It rises the cycle after a pop frees a slot.
- Output order equals acceptance order.

## Test plan
- Exact and in-range roots: after reset, send (p=16,u=4), (p=24,u=4), (p=0,u=0) with out_ready = 1 -> three outputs in order, all out_pass = 1, pass_count = 3, fail_count = 0, first out_valid one edge after first accept.
- Wrong roots: send (p=25,u=4) and (p=15,u=4) -> out_pass = 0 for both, fail_count = 2.
- Width boundary: send (p=65535,u=255) -> pass (sq_hi = 65536 needs 17 bits). Send (p=65535,u=254) -> fail.
- Backpressure at DEPTH = 4: out_ready = 0, in_valid held high for 6 cycles -> exactly 4 accepts, in_ready = 0 afterwards, out_p stable. Raise out_ready -> 4 results drain in order, in_ready returns 1 the cycle after the first pop.
- Clear collision and saturation: pulse clear on the same edge as a push -> counters read 0 after that edge and the entry still appears on the output. Preload 65535 passes -> pass_count stays 16'hFFFF after a further pass.
- Reset mid-stream: drop rst_n for one edge with 3 entries buffered and a_v = 1 -> out_valid = 0, counters = 0, in_ready = 1 on the next cycle, and no stale entry ever appears on the output.
